// File: rtl/reg_bank_arb_pkg.sv
// Shared types and width helpers for the register-bank access arbiter.
// Width helpers let parameterised modules size grant and timeout fields from their own parameters.
package reg_bank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF = 2;
  localparam int TIMEOUT_DEF = 15;

  // Grant index width, clamped to one bit so a single requester still gets a legal vector.
  function automatic int gnt_idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_gnt, wrapping around.
// Zero latency; no state, so the caller owns last_gnt and decides when a pick is taken.
module rr_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = gnt_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_req_o
);

  assign any_req_o = |req_i;

  always_comb begin
    logic found;
    int   j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    // Search starts one past the previous winner so last_gnt gets lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(last_gnt_i) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin sequencer sharing one register bank between NUM_REQ front-ends; one command per grant.
// Three cycles per command with an immediate bank_ack; status-half writes fail fast, stalls end in a timeout.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      ena_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_wr_rdn_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*REG_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      err_o,
  output logic [REG_W-1:0]          rdata_o,
  output logic                      bank_wr_rdn_o,
  output logic [ADDR_W-1:0]         bank_addr_o,
  output logic [REG_W-1:0]          bank_wdata_o,
  output logic                      bank_we_o,
  input  logic [REG_W-1:0]          bank_rdata_i,
  input  logic                      bank_ack_i,
  input  logic                      bank_err_i
);

  localparam int IDX_W = gnt_idx_w(NUM_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
  logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [REG_W-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [REG_W-1:0]    sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i      (req_i),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx),
    .any_req_o  (arb_any)
  );

  assign sel_wr    = req_wr_rdn_i[arb_idx];
  assign sel_addr  = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata_i[int'(arb_idx)*REG_W +: REG_W];

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_oh_d   = gnt_oh_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ena_i && arb_any) begin
          last_gnt_d = arb_idx;
          gnt_oh_d   = arb_gnt;
          wr_d       = sel_wr;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          cnt_d      = '0;
          // Status half is read-only: complete with an error without touching the bank.
          if (sel_wr && sel_addr[ADDR_W-1]) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bank_ack_i) begin
          if (!wr_q) rdata_d = bank_rdata_i;
          err_d   = bank_err_i;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      gnt_oh_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_oh_q   <= gnt_oh_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Bank command is only presented while in ACCESS so it reads as idle everywhere else.
  assign bank_we_o     = (state_q == ACCESS) && wr_q;
  assign bank_wr_rdn_o = (state_q == ACCESS) && wr_q;
  assign bank_addr_o   = (state_q == ACCESS) ? addr_q  : '0;
  assign bank_wdata_o  = (state_q == ACCESS) ? wdata_q : '0;

  assign ack_o   = (state_q == DONE) ? gnt_oh_q : '0;
  assign err_o   = (state_q == DONE) && err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with two requesters and a scripted bank.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [1:0]  req;
  logic [1:0]  req_wr_rdn;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        bank_wr_rdn;
  logic [7:0]  bank_addr;
  logic [7:0]  bank_wdata;
  logic        bank_we;
  logic [7:0]  bank_rdata;
  logic        bank_ack;
  logic        bank_err;

  int checks   = 0;
  int failures = 0;
  int we_cnt;
  logic [7:0] we_addr;
  logic [7:0] we_data;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.REG_W(8), .ADDR_W(8), .NUM_REQ(2), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .ena_i         (ena),
    .req_i         (req),
    .req_wr_rdn_i  (req_wr_rdn),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .ack_o         (ack),
    .err_o         (err),
    .rdata_o       (rdata),
    .bank_wr_rdn_o (bank_wr_rdn),
    .bank_addr_o   (bank_addr),
    .bank_wdata_o  (bank_wdata),
    .bank_we_o     (bank_we),
    .bank_rdata_i  (bank_rdata),
    .bank_ack_i    (bank_ack),
    .bank_err_i    (bank_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns later; also log any bank write seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bank_we) begin
      we_cnt++;
      we_addr = bank_addr;
      we_data = bank_wdata;
    end
  endtask

  // Returns the number of ticks until ack is seen, or -1 if the budget expires.
  task automatic wait_ack(input int budget, output int n, output logic [1:0] a);
    n = -1;
    a = 2'b00;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (ack != 2'b00) begin
        n = i;
        a = ack;
        break;
      end
    end
  endtask

  int         n;
  logic [1:0] a;
  logic [1:0] exp_ack;
  int         ack_seen;

  initial begin
    rstb       = 1'b0;
    ena        = 1'b1;
    req        = 2'b00;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h0000;
    req_wdata  = 16'h0000;
    bank_rdata = 8'h00;
    bank_ack   = 1'b1;
    bank_err   = 1'b0;
    we_cnt     = 0;
    we_addr    = 8'h00;
    we_data    = 8'h00;

    tick();
    tick();
    chk("reset_ack", {30'd0, ack}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);
    chk("reset_rdata", {24'd0, rdata}, 32'h0);
    chk("reset_bank", {15'd0, bank_we, bank_wr_rdn, bank_addr, bank_wdata}, 32'h0);
    rstb = 1'b1;
    tick();

    // Single read by requester 0.
    req        = 2'b01;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h0003;
    bank_rdata = 8'hA5;
    we_cnt     = 0;
    tick();
    chk("rd_cycle1_no_ack", {30'd0, ack}, 32'h0);
    chk("rd_bank_addr", {24'd0, bank_addr}, 32'h03);
    tick();
    chk("rd_ack", {30'd0, ack}, 32'h1);
    chk("rd_rdata", {24'd0, rdata}, 32'hA5);
    chk("rd_err", {31'd0, err}, 32'h0);
    req = 2'b00;
    tick();
    chk("rd_ack_one_cycle", {30'd0, ack}, 32'h0);
    chk("rd_no_we", we_cnt, 0);

    // Single write by requester 1.
    req        = 2'b10;
    req_wr_rdn = 2'b10;
    req_addr   = 16'h0200;
    req_wdata  = 16'h5C00;
    we_cnt     = 0;
    tick();
    tick();
    chk("wr_ack", {30'd0, ack}, 32'h2);
    chk("wr_err", {31'd0, err}, 32'h0);
    chk("wr_rdata_kept", {24'd0, rdata}, 32'hA5);
    req = 2'b00;
    tick();
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_we_addr", {24'd0, we_addr}, 32'h02);
    chk("wr_we_data", {24'd0, we_data}, 32'h5C);

    // Contention: both hold reads; last winner was 1, so 0,1,0,1 at ticks 2,5,8,11.
    req        = 2'b11;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h1110;
    for (int t = 1; t <= 11; t++) begin
      tick();
      case (t)
        2, 8:    exp_ack = 2'b01;
        5, 11:   exp_ack = 2'b10;
        default: exp_ack = 2'b00;
      endcase
      chk($sformatf("contend_t%0d", t), {30'd0, ack}, {30'd0, exp_ack});
    end
    req = 2'b00;
    tick();

    // ena low: nothing granted.
    ena      = 1'b0;
    req      = 2'b01;
    ack_seen = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (ack != 2'b00) ack_seen++;
    end
    chk("ena_off_no_ack", ack_seen, 0);
    req = 2'b00;
    ena = 1'b1;
    tick();

    // Illegal write into the status half.
    req        = 2'b01;
    req_wr_rdn = 2'b01;
    req_addr   = 16'h0081;
    req_wdata  = 16'h0077;
    we_cnt     = 0;
    wait_ack(4, n, a);
    chk("ill_ack_seen", (n > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("ill_ack_vec", {30'd0, a}, 32'h1);
    chk("ill_err", {31'd0, err}, 32'h1);
    chk("ill_rdata_kept", {24'd0, rdata}, 32'hA5);
    req = 2'b00;
    tick();
    tick();
    chk("ill_no_we", we_cnt, 0);

    // Timeout: tick 1 enters ACCESS, ack arrives 16 ticks later.
    bank_ack   = 1'b0;
    req        = 2'b01;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h0005;
    wait_ack(25, n, a);
    chk("to_ack_tick", n, 17);
    chk("to_ack_vec", {30'd0, a}, 32'h1);
    chk("to_err", {31'd0, err}, 32'h1);
    chk("to_rdata", {24'd0, rdata}, 32'h00);
    req = 2'b00;
    tick();

    // Reset during an ACCESS write from requester 0.
    rdata_seed();
    req        = 2'b01;
    req_wr_rdn = 2'b01;
    req_addr   = 16'h0001;
    req_wdata  = 16'h0033;
    tick();
    chk("rst_pre_we", {31'd0, bank_we}, 32'h1);
    #1 rstb = 1'b0;
    #1;
    chk("rst_bank_idle", {15'd0, bank_we, bank_wr_rdn, bank_addr, bank_wdata}, 32'h0);
    chk("rst_outs", {21'd0, ack, err, rdata}, 32'h0);
    req      = 2'b00;
    ack_seen = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (ack != 2'b00) ack_seen++;
    end
    chk("rst_no_ack", ack_seen, 0);
    rstb       = 1'b1;
    bank_ack   = 1'b1;
    req        = 2'b11;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h0403;
    wait_ack(6, n, a);
    chk("rst_first_winner", {30'd0, a}, 32'h1);
    req = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Puts a non-zero value into rdata so a reset visibly clears it.
  task automatic rdata_seed();
    req        = 2'b01;
    req_wr_rdn = 2'b00;
    req_addr   = 16'h0007;
    bank_rdata = 8'h3C;
    bank_ack   = 1'b1;
    wait_ack(6, n, a);
    chk("seed_rdata", {24'd0, rdata}, 32'h3C);
    req = 2'b00;
    tick();
    bank_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
